// File: rtl/aes_controller_pkg.sv
// aes_controller_pkg
//   Shared definitions for the AES sequencer: block/key widths, the
//   controller state encoding and the bit positions inside the sticky
//   error vector.
package aes_controller_pkg;

  localparam int KEY_S = 128;  // key width in bits
  localparam int BLK_S = 128;  // block width in bits
  localparam int NK    = 4;    // key length in 32-bit words (AES-128)

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_START = 2'd1,
    CTRL_WAIT  = 2'd2,
    CTRL_OUT   = 2'd3
  } ctrl_state_t;

  localparam int ERR_TIMEOUT = 0;  // err[0]: core never signalled done
  localparam int ERR_NOKEY   = 1;  // err[1]: plaintext arrived before any key

endpackage

// File: rtl/aes_ctrl_watchdog.sv
// aes_ctrl_watchdog
//   Loadable down-counter guarding the WAIT state.
//   Ports:
//     clk, reset  - clock and synchronous active-high reset
//     i_load      - reload the counter with TIMEOUT-1
//     i_en        - count down by one (saturates at zero)
//     o_expired   - counter has reached zero
//   After a load the counter spends TIMEOUT enabled cycles before
//   o_expired is seen, i.e. expiry coincides with the TIMEOUT-th cycle.
module aes_ctrl_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/aes_controller.sv
// aes_controller
//   Sequencer between a 128-bit valid/ready command stream and an AES core.
//   Ports:
//     clk, reset        - clock, synchronous active-high reset
//     s_valid/s_ready   - input beat handshake; s_key selects key vs plaintext
//     s_data            - key or plaintext
//     m_valid/m_ready   - ciphertext output handshake, m_data is the block
//     aes_en            - one-cycle start pulse to the core
//     aes_key_strobe    - key expansion request, held for the whole operation
//     aes_key           - key register driven to the core
//     aes_plaintext     - plaintext register driven to the core
//     aes_en_o          - core done pulse, aes_ciphertext valid with it
//     busy              - controller not idle
//     err               - sticky: [0] watchdog timeout, [1] plaintext w/o key
//     err_clr           - clears err, wins over a same-cycle set
//     blocks_done       - ciphertexts accepted downstream (wrapping)
module aes_controller
  import aes_controller_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_key,
  input  logic [BLK_S-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_S-1:0] m_data,
  output logic             aes_en,
  output logic             aes_key_strobe,
  output logic [KEY_S-1:0] aes_key,
  output logic [BLK_S-1:0] aes_plaintext,
  input  logic             aes_en_o,
  input  logic [BLK_S-1:0] aes_ciphertext,
  output logic             busy,
  output logic [1:0]       err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] blocks_done
);

  ctrl_state_t      r_state,     w_state_next;
  logic [KEY_S-1:0] r_key,       w_key_next;
  logic [BLK_S-1:0] r_pt,        w_pt_next;
  logic [BLK_S-1:0] r_m_data,    w_m_data_next;
  logic             r_m_valid,   w_m_valid_next;
  logic             r_key_valid, w_key_valid_next;
  logic             r_key_dirty, w_key_dirty_next;
  logic             r_strobe,    w_strobe_next;
  logic [1:0]       r_err,       w_err_next;
  logic [1:0]       w_err_set;
  logic [CNT_W-1:0] r_blocks,    w_blocks_next;

  logic w_s_fire;
  logic w_wd_load;
  logic w_wd_en;
  logic w_wd_expired;

  // s_ready is masked by reset so it reads 0 while reset is held, even if
  // the state register has not yet returned to IDLE.
  assign s_ready  = (r_state == CTRL_IDLE) && !reset;
  assign w_s_fire = s_valid && s_ready;

  aes_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_wd_load),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CTRL_IDLE;
      r_key       <= '0;
      r_pt        <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_dirty <= 1'b0;
      r_strobe    <= 1'b0;
      r_err       <= '0;
      r_blocks    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_key       <= w_key_next;
      r_pt        <= w_pt_next;
      r_m_data    <= w_m_data_next;
      r_m_valid   <= w_m_valid_next;
      r_key_valid <= w_key_valid_next;
      r_key_dirty <= w_key_dirty_next;
      r_strobe    <= w_strobe_next;
      r_err       <= w_err_next;
      r_blocks    <= w_blocks_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_key_next       = r_key;
    w_pt_next        = r_pt;
    w_m_data_next    = r_m_data;
    w_m_valid_next   = r_m_valid;
    w_key_valid_next = r_key_valid;
    w_key_dirty_next = r_key_dirty;
    w_strobe_next    = r_strobe;
    w_blocks_next    = r_blocks;
    w_err_set        = 2'b00;
    w_wd_load        = 1'b0;
    w_wd_en          = 1'b0;

    case (r_state)
      CTRL_IDLE: begin
        if (w_s_fire) begin
          if (s_key) begin
            // Any key load, even a repeat of the same value, forces the
            // next block to re-expand.
            w_key_next       = s_data;
            w_key_valid_next = 1'b1;
            w_key_dirty_next = 1'b1;
          end else if (!r_key_valid) begin
            w_err_set[ERR_NOKEY] = 1'b1;
          end else begin
            w_pt_next     = s_data;
            w_strobe_next = r_key_dirty;
            w_state_next  = CTRL_START;
          end
        end
      end

      CTRL_START: begin
        w_wd_load    = 1'b1;
        w_state_next = CTRL_WAIT;
      end

      CTRL_WAIT: begin
        w_wd_en = 1'b1;
        // The done pulse is tested first so it wins over a simultaneous expiry.
        if (aes_en_o) begin
          w_m_data_next    = aes_ciphertext;
          w_m_valid_next   = 1'b1;
          w_key_dirty_next = 1'b0;
          w_strobe_next    = 1'b0;
          w_state_next     = CTRL_OUT;
        end else if (w_wd_expired) begin
          // Core state is unknown after an abort, so the round keys
          // cannot be trusted: re-expand on the next block.
          w_err_set[ERR_TIMEOUT] = 1'b1;
          w_strobe_next          = 1'b0;
          w_key_dirty_next       = 1'b1;
          w_state_next           = CTRL_IDLE;
        end
      end

      CTRL_OUT: begin
        if (m_ready) begin
          w_m_valid_next = 1'b0;
          w_blocks_next  = r_blocks + CNT_W'(1);
          w_state_next   = CTRL_IDLE;
        end
      end

      default: begin
        w_state_next = CTRL_IDLE;
      end
    endcase

    w_err_next = err_clr ? 2'b00 : (r_err | w_err_set);
  end

  assign m_valid        = r_m_valid;
  assign m_data         = r_m_data;
  assign aes_en         = (r_state == CTRL_START);
  assign aes_key_strobe = r_strobe;
  assign aes_key        = r_key;
  assign aes_plaintext  = r_pt;
  assign busy           = (r_state != CTRL_IDLE);
  assign err            = r_err;
  assign blocks_done    = r_blocks;

endmodule
